// File: rtl/lsu_mem_pkg.sv
// Shared types and helpers for the LSU data-memory responder.
package lsu_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  // Merge a store into an existing word: enabled bytes take wdata, others keep old.
  function automatic logic [WORD_W-1:0] be_merge(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] wdata,
    input logic [BE_W-1:0]   be
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/lsu_mem_array.sv
// Word-addressed register file with byte-enable write, async read and a flattened dump.
module lsu_mem_array
  import lsu_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned AW        = $clog2(NUM_WORDS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        we_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [WORD_W-1:0]           wdata_i,
  input  logic [BE_W-1:0]             be_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [WORD_W-1:0]           rdata_o,
  output logic [WORD_W*NUM_WORDS-1:0] mem_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] mem_d [NUM_WORDS];

  // Next memory image: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (we_i) mem_d[waddr_i] = be_merge(mem_q[waddr_i], wdata_i, be_i);
  end

  // Storage registers, cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_dump
    assign mem_o[WORD_W*g +: WORD_W] = mem_q[g];
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// LSU data-memory responder: single outstanding request, programmable latency,
// stallable countdown, byte-enable stores and a range-checked backing store.
module lsu_mem_responder
  import lsu_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 32,
  parameter int unsigned LOAD_LAT  = 1,
  parameter int unsigned STORE_LAT = 1,
  parameter int unsigned LAT_W     = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic                        req_we_i,
  input  logic [31:0]                 req_addr_i,
  input  logic [31:0]                 req_wdata_i,
  input  logic [3:0]                  req_be_i,
  input  logic                        stall_i,
  output logic                        load_mem_resp_o,
  output logic                        store_mem_resp_o,
  output logic [31:0]                 rdata_o,
  output logic                        err_o,
  output logic [32*NUM_WORDS-1:0]     mem_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam logic [LAT_W-1:0] LOAD_CNT  = LAT_W'(LOAD_LAT);
  localparam logic [LAT_W-1:0] STORE_CNT = LAT_W'(STORE_LAT);

  resp_state_e       state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;

  logic              in_range;
  logic [AW-1:0]     word_idx;
  logic              mem_we;
  logic [31:0]       arr_rdata;
  logic              addr_lo_unused;

  // Byte offset within a word carries no meaning here.
  assign addr_lo_unused = ^addr_q[1:0];
  assign in_range = (addr_q[31:AW+2] == '0);
  assign word_idx = addr_q[AW+1:2];

  // Next-state, request latch, countdown and response outputs.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    req_ready_o      = 1'b0;
    load_mem_resp_o  = 1'b0;
    store_mem_resp_o = 1'b0;
    rdata_o          = '0;
    err_o            = 1'b0;
    mem_we           = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          be_d    = req_be_i;
          if (req_we_i) begin
            cnt_d   = STORE_CNT;
            state_d = (STORE_LAT == 0) ? RESP : WAIT;
          end else begin
            cnt_d   = LOAD_CNT;
            state_d = (LOAD_LAT == 0) ? RESP : WAIT;
          end
        end
      end
      WAIT: begin
        if (!stall_i) begin
          cnt_d = cnt_q - LAT_W'(1);
          if (cnt_q == LAT_W'(1)) state_d = RESP;
        end
      end
      RESP: begin
        store_mem_resp_o = we_q;
        load_mem_resp_o  = !we_q;
        err_o            = !in_range;
        rdata_o          = (!we_q && in_range) ? arr_rdata : '0;
        mem_we           = we_q && in_range;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  lsu_mem_array #(
    .NUM_WORDS (NUM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (word_idx),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .raddr_i (word_idx),
    .rdata_o (arr_rdata),
    .mem_o   (mem_o)
  );

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: two instances (LAT 1/1 and LOAD 0 / STORE 2).
module tb_lsu_mem_responder;

  typedef struct {
    bit          we;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid [2];
  logic          we    [2];
  logic          stall [2];
  logic [31:0]   addr  [2];
  logic [31:0]   wdata [2];
  logic [3:0]    be    [2];
  logic          ready [2];
  logic          ld    [2];
  logic          st    [2];
  logic          err   [2];
  logic [31:0]   rdata [2];
  logic [1023:0] mem_o [2];

  logic [31:0]   exp_mem [2][32];
  resp_t         q0 [$];
  resp_t         q1 [$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_responder #(
    .NUM_WORDS (32), .LOAD_LAT (1), .STORE_LAT (1), .LAT_W (4)
  ) u_dut_a (
    .clk_i (clk), .rst_ni (rst_n), .req_valid_i (valid[0]), .req_ready_o (ready[0]),
    .req_we_i (we[0]), .req_addr_i (addr[0]), .req_wdata_i (wdata[0]), .req_be_i (be[0]),
    .stall_i (stall[0]), .load_mem_resp_o (ld[0]), .store_mem_resp_o (st[0]),
    .rdata_o (rdata[0]), .err_o (err[0]), .mem_o (mem_o[0])
  );

  lsu_mem_responder #(
    .NUM_WORDS (32), .LOAD_LAT (0), .STORE_LAT (2), .LAT_W (4)
  ) u_dut_b (
    .clk_i (clk), .rst_ni (rst_n), .req_valid_i (valid[1]), .req_ready_o (ready[1]),
    .req_we_i (we[1]), .req_addr_i (addr[1]), .req_wdata_i (wdata[1]), .req_be_i (be[1]),
    .stall_i (stall[1]), .load_mem_resp_o (ld[1]), .store_mem_resp_o (st[1]),
    .rdata_o (rdata[1]), .err_o (err[1]), .mem_o (mem_o[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    return {b[3] ? n[31:24] : o[31:24], b[2] ? n[23:16] : o[23:16],
            b[1] ? n[15:8]  : o[15:8],  b[0] ? n[7:0]   : o[7:0]};
  endfunction

  // Monitor: pops the scoreboard whenever a response pulse appears.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        resp_t e;
        bit    have;
        have = 1'b0;
        if (ld[d] || st[d]) begin
          if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          else if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp dut%0d: got load=%0b store=%0b, required no response", d, ld[d], st[d]);
          end else begin
            chk($sformatf("resp_kind_d%0d", d), {30'b0, ld[d], st[d]}, {30'b0, !e.we, e.we});
            chk($sformatf("resp_cycle_d%0d", d), cyc, e.cyc);
            chk($sformatf("resp_err_d%0d", d), {31'b0, err[d]}, {31'b0, e.err});
            chk($sformatf("resp_rdata_d%0d", d), rdata[d], e.we ? 32'h0 : e.rdata);
          end
        end else begin
          chk($sformatf("idle_rdata_d%0d", d), rdata[d], 32'h0);
          chk($sformatf("idle_err_d%0d", d), {31'b0, err[d]}, 32'h0);
        end
      end
    end
  end

  task automatic check_mem(input int d);
    for (int i = 0; i < 32; i++)
      chk($sformatf("mem_d%0d_w%0d", d, i), mem_o[d][32*i +: 32], exp_mem[d][i]);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("wait_idle_timeout", 32'(q0.size() + q1.size()), 32'h0);
  endtask

  task automatic issue(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] b, input int lat, input int stalls,
                       input bit e_err, input logic [31:0] e_rdata, output int acc);
    int    n = 0;
    resp_t e;
    while (ready[d] !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("ready_timeout", {31'b0, ready[d]}, 32'h1);
    valid[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd; be[d] = b;
    @(posedge clk); #1;
    valid[d] = 1'b0;
    acc = cyc;
    e.we = w; e.err = e_err; e.rdata = e_rdata; e.cyc = cyc + lat + stalls;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    if (w && !e_err) exp_mem[d][a[6:2]] = merge(exp_mem[d][a[6:2]], wd, b);
    if (stalls > 0) begin
      stall[d] = 1'b1;
      for (int s = 0; s < stalls; s++) begin
        valid[d] = 1'b1; we[d] = 1'b1; addr[d] = 32'h4; wdata[d] = 32'hFFFF_FFFF; be[d] = 4'hF;
        chk("ready_in_wait", {31'b0, ready[d]}, 32'h0);
        @(posedge clk); #1;
      end
      stall[d] = 1'b0;
      valid[d] = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    for (int d = 0; d < 2; d++) begin
      valid[d] = 1'b0; we[d] = 1'b0; stall[d] = 1'b0;
      addr[d] = '0; wdata[d] = '0; be[d] = '0;
      for (int i = 0; i < 32; i++) exp_mem[d][i] = 32'h0;
    end

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'b0, ready[d]}, 32'h1);
      chk("rst_load", {31'b0, ld[d]}, 32'h0);
      chk("rst_store", {31'b0, st[d]}, 32'h0);
      check_mem(d);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-WAIT discards the pending store without a response.
    valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h1234_5678; be[0] = 4'hF;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("accepted_ready_low", {31'b0, ready[0]}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", {31'b0, ready[0]}, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_mem(0);

    // Store then load, latency 1.
    issue(0, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 1, 0, 1'b0, 32'h0, a0);
    wait_idle();
    check_mem(0);
    issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 1, 0, 1'b0, 32'hDEAD_BEEF, a0);

    // Byte enables and the be=0 no-op store.
    issue(0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 1, 0, 1'b0, 32'h0, a0);
    issue(0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 1, 0, 1'b0, 32'h0, a0);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 0, 1'b0, 32'h11BB_33DD, a0);
    issue(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 1, 0, 1'b0, 32'h0, a0);
    issue(0, 1'b0, 32'h3, 32'h0, 4'h0, 1, 0, 1'b0, 32'h11BB_33DD, a0);

    // Range boundary: last word in range, first word out of range.
    issue(0, 1'b1, 32'h80, 32'h5555_5555, 4'hF, 1, 0, 1'b1, 32'h0, a0);
    issue(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 1, 0, 1'b1, 32'h0, a0);
    issue(0, 1'b1, 32'h7C, 32'h1234_A5A5, 4'b0011, 1, 0, 1'b0, 32'h0, a0);
    issue(0, 1'b0, 32'h7F, 32'h0, 4'h0, 1, 0, 1'b0, 32'h0000_A5A5, a0);

    // Stalled load on the latency-1 instance; back-to-back interval is LAT+2.
    issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 1, 2, 1'b0, 32'hDEAD_BEEF, a0);
    wait_idle();
    issue(0, 1'b0, 32'h8, 32'h0, 4'h0, 1, 0, 1'b0, 32'hDEAD_BEEF, a1);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 0, 1'b0, 32'h11BB_33DD, a2);
    chk("interval_lat1", 32'(a2 - a1), 32'd3);
    wait_idle();
    check_mem(0);

    // Latency-2 store with three stalled WAIT cycles and ignored requests.
    issue(1, 1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, 2, 3, 1'b0, 32'h0, a0);
    wait_idle();
    check_mem(1);

    // Zero-latency loads, back to back every two cycles.
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFE_F00D, a1);
    issue(1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 0, 1'b0, 32'h0, a2);
    chk("interval_lat0", 32'(a2 - a1), 32'd2);
    issue(1, 1'b0, 32'h13, 32'h0, 4'h0, 0, 0, 1'b0, 32'hCAFE_F00D, a1);
    issue(1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 0, 1'b1, 32'h0, a1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_mem(0);
    check_mem(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
